// File: rtl/random_ctrl_pkg.sv
// random_ctrl_pkg: shared state type and LFSR constants for random_cmd_gen
package random_ctrl_pkg;
  typedef enum logic {IDLE, RUN} rcg_state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int LFSR_W = 16;
endpackage

// File: rtl/random_cmd_gen_if.sv
// random_cmd_gen_if: button input and command outputs toward the motor control stage
interface random_cmd_gen_if;
  logic btn;
  logic [3:0] rand_num;
  logic start;
  logic busy;
  logic cmd_done;
  modport master (input btn, output rand_num, start, busy, cmd_done);
  modport slave (output btn, input rand_num, start, busy, cmd_done);
endinterface

// File: rtl/galois_lfsr.sv
// galois_lfsr: free-running Galois LFSR with an all-zero lock-up guard
module galois_lfsr #(
  parameter int W = 16,
  parameter logic [W-1:0] TAPS = '1,
  parameter logic [W-1:0] SEED = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [W-1:0] state
);
  localparam logic [W-1:0] INIT = (SEED == '0) ? W'(1) : SEED;
  logic [W-1:0] state_q, state_d;
  always_comb state_d = (state_q == '0) ? W'(1) : (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
  always_ff @(posedge clk) state_q <= !rst_n ? INIT : state_d;
  assign state = state_q;
endmodule

// File: rtl/random_cmd_gen.sv
// random_cmd_gen: debounced button press latches a random nibble and runs a fixed start window
module random_cmd_gen
  import random_ctrl_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_CYCLES = 100000000
) (
  input logic clk,
  input logic rst_n,
  random_cmd_gen_if.master bus
);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(RUN_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(RUN_CYCLES - 1);
  logic [LFSR_W-1:0] lfsr;
  logic lfsr_unused;
  logic [1:0] sync_q, sync_d;
  logic db_q, db_d, db_prev_q;
  logic [DBW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] run_q, run_d;
  rcg_state_t state_q, state_d;
  logic [3:0] rand_q, rand_d;
  logic done_q, done_d;
  logic press, last;
  galois_lfsr #(.W(LFSR_W), .TAPS(LFSR_TAPS), .SEED(SEED)) u_lfsr (
    .clk(clk), .rst_n(rst_n), .state(lfsr)
  );
  assign lfsr_unused = ^lfsr[LFSR_W-1:4];
  always_comb begin
    sync_d = {sync_q[0], bus.btn};
    cnt_d = (sync_q[1] == db_q || cnt_q == DB_LAST) ? '0 : cnt_q + 1'b1;
    db_d = (sync_q[1] != db_q && cnt_q == DB_LAST) ? sync_q[1] : db_q;
    press = db_q & ~db_prev_q;
    last = state_q == RUN && run_q == RUN_LAST;
    state_d = (state_q == IDLE) ? (press ? RUN : IDLE) : (last ? IDLE : RUN);
    run_d = (state_q == RUN && !last) ? run_q + 1'b1 : '0;
    rand_d = (state_q == IDLE && press) ? lfsr[3:0] : rand_q;
    done_d = last;
  end
  // reset mid-run drops straight to idle with no done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      db_q <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q <= '0;
      run_q <= '0;
      state_q <= IDLE;
      rand_q <= '0;
      done_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      db_q <= db_d;
      db_prev_q <= db_q;
      cnt_q <= cnt_d;
      run_q <= run_d;
      state_q <= state_d;
      rand_q <= rand_d;
      done_q <= done_d;
    end
  end
  assign bus.rand_num = rand_q;
  assign bus.start = state_q == RUN;
  assign bus.busy = state_q == RUN;
  assign bus.cmd_done = done_q;
endmodule

// File: tb/tb_random_cmd_gen.sv
// tb_random_cmd_gen: directed stimulus against a cycle model of the command generator
module tb_random_cmd_gen;
  import random_ctrl_pkg::*;
  localparam int DB = 4;
  localparam int RUN = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  random_cmd_gen_if bus ();
  random_cmd_gen_if bus0 ();
  random_cmd_gen #(.SEED(16'hACE1), .DEBOUNCE_CYCLES(DB), .RUN_CYCLES(RUN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  random_cmd_gen #(.SEED(16'h0000), .DEBOUNCE_CYCLES(DB), .RUN_CYCLES(RUN)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  int vectors = 0;
  int errors = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] step(input logic [15:0] x);
    return x == 16'h0 ? 16'h0001 : (x[0] ? (x >> 1) ^ LFSR_TAPS : x >> 1);
  endfunction
  // model: countdown of remaining run cycles, streak of disagreeing samples
  logic [15:0] m_lfsr;
  logic [1:0] m_sync;
  logic m_db, m_db_prev, m_done;
  int m_streak, m_left;
  logic [3:0] m_rand;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_lfsr <= 16'hACE1;
      m_sync <= 2'b0;
      m_db <= 1'b0;
      m_db_prev <= 1'b0;
      m_streak <= 0;
      m_left <= 0;
      m_rand <= 4'h0;
      m_done <= 1'b0;
    end else begin
      m_lfsr <= step(m_lfsr);
      m_sync <= {m_sync[0], bus.btn};
      if (m_sync[1] != m_db && m_streak + 1 == DB) begin
        m_db <= m_sync[1];
        m_streak <= 0;
      end else m_streak <= (m_sync[1] != m_db) ? m_streak + 1 : 0;
      m_db_prev <= m_db;
      m_done <= (m_left == 1);
      if (m_left > 0) m_left <= m_left - 1;
      else if (m_db && !m_db_prev) begin
        m_left <= RUN;
        m_rand <= m_lfsr[3:0];
      end
    end
  end
  bit chk_en = 1'b0;
  logic prev_start = 1'b0;
  int highs = 0, rises = 0, dones = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("start", bus.start, m_left > 0);
      check("busy", bus.busy, m_left > 0);
      check("cmd_done", bus.cmd_done, m_done);
      check("rand_num", bus.rand_num, m_rand);
      check("lfsr", dut.lfsr, m_lfsr);
      if (bus.cmd_done) check("done_align", {prev_start, bus.start}, 2'b10);
      highs <= highs + int'(bus.start);
      rises <= rises + int'(bus.start && !prev_start);
      dones <= dones + int'(bus.cmd_done);
      prev_start <= bus.start;
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  int r0, h0, d0;
  logic [3:0] rnd;
  initial begin
    bus.btn = 1'b0;
    bus0.btn = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    cyc(2);
    check("seed0_reset", dut0.lfsr, 16'h0001);
    check("lfsr_reset", dut.lfsr, 16'hACE1);
    check("outs_reset", {bus.start, bus.busy, bus.cmd_done, bus.rand_num}, 7'h0);
    rst_n = 1'b1;
    cyc(1);
    check("lfsr_1", dut.lfsr, 16'hE270);
    check("seed0_1", dut0.lfsr, 16'hB400);
    cyc(1);
    check("lfsr_2", dut.lfsr, 16'h7138);
    cyc(1);
    check("lfsr_3", dut.lfsr, 16'h389C);
    // three-cycle bounce never debounces
    r0 = rises;
    bus.btn = 1'b1;
    cyc(3);
    bus.btn = 1'b0;
    cyc(12);
    check("bounce_rises", rises - r0, 0);
    check("bounce_db", dut.db_q, 1'b0);
    // press, then a second debounced press landing in the last run cycle
    r0 = rises; h0 = highs; d0 = dones;
    bus.btn = 1'b1;
    cyc(4);
    bus.btn = 1'b0;
    cyc(4);
    bus.btn = 1'b1;
    check("run_started", bus.start, 1'b1);
    rnd = bus.rand_num;
    cyc(20);
    check("drop_rises", rises - r0, 1);
    check("drop_highs", highs - h0, RUN);
    check("drop_dones", dones - d0, 1);
    check("drop_rand", bus.rand_num, rnd);
    bus.btn = 1'b0;
    cyc(12);
    // press landing on the cmd_done cycle
    r0 = rises; h0 = highs;
    bus.btn = 1'b1;
    cyc(4);
    bus.btn = 1'b0;
    cyc(5);
    bus.btn = 1'b1;
    cyc(5);
    check("b2b_last_run", bus.start, 1'b1);
    cyc(1);
    check("b2b_gap", {bus.start, bus.cmd_done}, 2'b01);
    cyc(1);
    check("b2b_restart", bus.start, 1'b1);
    cyc(7);
    check("b2b_run8", bus.start, 1'b1);
    cyc(1);
    check("b2b_end", {bus.start, bus.cmd_done}, 2'b01);
    check("b2b_rises", rises - r0, 2);
    check("b2b_highs", highs - h0, 2 * RUN);
    bus.btn = 1'b0;
    cyc(12);
    // reset in the third run cycle
    bus.btn = 1'b1;
    cyc(4);
    bus.btn = 1'b0;
    cyc(3);
    check("rst_run1", bus.start, 1'b1);
    cyc(2);
    rst_n = 1'b0;
    cyc(1);
    check("rst_abort", {bus.start, bus.busy, bus.cmd_done, bus.rand_num}, 7'h0);
    rst_n = 1'b1;
    d0 = dones;
    cyc(12);
    check("rst_no_done", dones - d0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
